// File: rtl/chromosome_loader.sv
// rtl/chromosome_loader.sv - serial chromosome loader with shadow bank and parity-checked commit
//
// Receives a serial configuration frame of N_LE 9-bit genes followed by one
// even-parity bit. Data bits fill a shadow bank. The visible configuration
// buses change only when a frame completes with correct parity.
//
// Ports:
//   clk           - single clock; all state changes on its rising edge
//   rst_n         - asynchronous active-low reset
//   start         - request a new load (honoured only in IDLE)
//   abort         - cancel a load in progress (ignored in IDLE)
//   bit_in        - serial frame data
//   bit_valid     - bit_in is valid this cycle
//   bit_ready     - a bit is accepted this cycle (high while SHIFT)
//   conf_func_bus - per-LE function select, LE k at [3k+2:3k]
//   conf_ins_bus  - per-LE input select, LE k at [6k+5:6k]
//   busy          - a load is in progress
//   done          - one-cycle pulse after a configuration is committed
//   err           - one-cycle pulse after a frame is rejected on parity

module chromosome_loader #(
    parameter int N_LE = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic                bit_in,
    input  logic                bit_valid,
    output logic                bit_ready,
    output logic [3*N_LE-1:0]   conf_func_bus,
    output logic [6*N_LE-1:0]   conf_ins_bus,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int FRAME_BITS = N_LE * 9;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [CNT_W-1:0]        bit_cnt_q;
    logic                    parity_q;
    logic [FRAME_BITS-1:0]   shadow_q;
    logic [3*N_LE-1:0]       func_q;
    logic [6*N_LE-1:0]       ins_q;
    logic                    done_q;
    logic                    err_q;

    logic                    accept;
    logic                    at_parity;
    logic [3*N_LE-1:0]       func_next;
    logic [6*N_LE-1:0]       ins_next;

    assign accept    = bit_valid && (state_q == SHIFT);
    // Once all data bits are in, the next accepted bit is the parity bit.
    assign at_parity = (bit_cnt_q == CNT_W'(FRAME_BITS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (accept && at_parity) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The shadow bank shifts in at the LSB, so the first bit sent (gene 0
    // MSB) ends at the top. Gene k therefore sits at
    // shadow[9*(N_LE-k)-1 -: 9] as {func[2:0], ins[5:0]}.
    always_comb begin
        func_next = '0;
        ins_next  = '0;
        for (int k = 0; k < N_LE; k++) begin
            func_next[3*k +: 3] = shadow_q[9*(N_LE-k)-1 -: 3];
            ins_next[6*k +: 6]  = shadow_q[9*(N_LE-k)-4 -: 6];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
            shadow_q  <= '0;
            func_q    <= '0;
            ins_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (state_q == IDLE) begin
                if (start) begin
                    bit_cnt_q <= '0;
                    parity_q  <= 1'b0;
                    shadow_q  <= '0;
                end
            end else if (abort) begin
                // Abort beats any bit accepted in the same cycle.
                shadow_q <= '0;
            end else if (accept) begin
                if (!at_parity) begin
                    if (FRAME_BITS > 1) begin
                        shadow_q <= {shadow_q[FRAME_BITS-2:0], bit_in};
                    end else begin
                        shadow_q <= bit_in;
                    end
                    parity_q  <= parity_q ^ bit_in;
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                end else if (bit_in == parity_q) begin
                    func_q <= func_next;
                    ins_q  <= ins_next;
                    done_q <= 1'b1;
                end else begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign bit_ready     = (state_q == SHIFT);
    assign busy          = (state_q == SHIFT);
    assign done          = done_q;
    assign err           = err_q;
    assign conf_func_bus = func_q;
    assign conf_ins_bus  = ins_q;

endmodule

// File: tb/tb_chromosome_loader.sv
// tb/tb_chromosome_loader.sv - self-checking bench for chromosome_loader (N_LE = 2)

module tb_chromosome_loader;

    localparam int N_LE = 2;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic                abort;
    logic                bit_in;
    logic                bit_valid;
    logic                bit_ready;
    logic [3*N_LE-1:0]   conf_func_bus;
    logic [6*N_LE-1:0]   conf_ins_bus;
    logic                busy;
    logic                done;
    logic                err;

    chromosome_loader #(.N_LE(N_LE)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .bit_in        (bit_in),
        .bit_valid     (bit_valid),
        .bit_ready     (bit_ready),
        .conf_func_bus (conf_func_bus),
        .conf_ins_bus  (conf_ins_bus),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 = no pulse, 1 = done, 2 = err
    typedef struct {
        logic [17:0] data;
        logic        par;
        int          abort_idx;
        bit          gaps;
        bit          glitch;
        logic [1:0]  kind;
        logic [5:0]  func;
        logic [11:0] ins;
    } vec_t;

    typedef struct {
        logic [1:0]  kind;
        logic [5:0]  func;
        logic [11:0] ins;
    } exp_t;

    vec_t        vecs[8];
    exp_t        sb[$];
    int          total;
    int          bad;
    bit          mon_en;
    logic [5:0]  model_func;
    logic [11:0] model_ins;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard consumer: every done/err pulse pops one expectation; on all
    // other cycles the buses must hold the last committed configuration.
    always @(negedge clk) begin
        if (mon_en) begin
            if (done || err) begin
                check("done_err_exclusive", {31'd0, done && err}, 32'd0);
                if (sb.size() == 0) begin
                    check("unexpected_pulse", {30'd0, err, done}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("pulse_kind", {30'd0, err, done}, {30'd0, e.kind});
                    check("pulse_func", {26'd0, conf_func_bus}, {26'd0, e.func});
                    check("pulse_ins", {20'd0, conf_ins_bus}, {20'd0, e.ins});
                    model_func = e.func;
                    model_ins  = e.ins;
                end
            end else begin
                check("hold_func", {26'd0, conf_func_bus}, {26'd0, model_func});
                check("hold_ins", {20'd0, conf_ins_bus}, {20'd0, model_ins});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // The start cycle always carries bit_valid=1 so an erroneous capture
    // would corrupt both data and parity.
    task automatic run_frame(input logic [17:0] d, input logic p, input int abort_idx,
                             input bit gaps, input bit glitch);
        logic b;
        start     = 1'b1;
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        tick();
        start     = 1'b0;
        bit_valid = 1'b0;
        for (int i = 0; i < 19; i++) begin
            b = (i < 18) ? d[17-i] : p;
            if (gaps) begin
                for (int g = $urandom_range(0, 3); g > 0; g--) begin
                    bit_valid = 1'b0;
                    bit_in    = ~b;
                    tick();
                end
            end
            bit_in    = b;
            bit_valid = 1'b1;
            abort     = (i == abort_idx);
            start     = glitch && (i == 4);
            tick();
            bit_valid = 1'b0;
            abort     = 1'b0;
            start     = 1'b0;
            if (i == abort_idx) break;
        end
    endtask

    task automatic push_exp(input logic [1:0] kind, input logic [5:0] f, input logic [11:0] n);
        exp_t e;
        e.kind = kind;
        e.func = f;
        e.ins  = n;
        if (kind != 2'd0) sb.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total      = 0;
        bad        = 0;
        mon_en     = 1'b0;
        model_func = '0;
        model_ins  = '0;
        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        bit_in     = 1'b0;
        bit_valid  = 1'b0;

        vecs[0] = '{18'b011010001_001000101, 1'b1, -1, 1'b1, 1'b0, 2'd1, 6'o13, 12'o0521};
        vecs[1] = '{18'b011010001_001000101, 1'b0, -1, 1'b1, 1'b0, 2'd2, 6'o13, 12'o0521};
        vecs[2] = '{18'b000000000_000000000, 1'b0, -1, 1'b0, 1'b0, 2'd1, 6'o00, 12'o0000};
        vecs[3] = '{18'b000000000_000000000, 1'b1, -1, 1'b0, 1'b0, 2'd2, 6'o00, 12'o0000};
        vecs[4] = '{18'b111111111_000000000, 1'b1, -1, 1'b1, 1'b0, 2'd1, 6'o07, 12'o0077};
        vecs[5] = '{18'b011010001_001000101, 1'b1,  9, 1'b0, 1'b0, 2'd0, 6'o07, 12'o0077};
        vecs[6] = '{18'b011010001_001000101, 1'b1, 18, 1'b1, 1'b0, 2'd0, 6'o07, 12'o0077};
        vecs[7] = '{18'b011010001_001000101, 1'b1, -1, 1'b1, 1'b1, 2'd1, 6'o13, 12'o0521};

        // Reset then idle.
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, bit_ready}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_func", {26'd0, conf_func_bus}, 32'd0);
        check("rst_ins", {20'd0, conf_ins_bus}, 32'd0);
        mon_en = 1'b1;

        // abort in IDLE does nothing
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_abort_busy", {31'd0, busy}, 32'd0);

        for (int v = 0; v < 8; v++) begin
            push_exp(vecs[v].kind, vecs[v].func, vecs[v].ins);
            run_frame(vecs[v].data, vecs[v].par, vecs[v].abort_idx, vecs[v].gaps, vecs[v].glitch);
            check($sformatf("v%0d_idle_after", v), {31'd0, busy}, 32'd0);
            tick();
            tick();
            check($sformatf("v%0d_pulse_seen", v), sb.size(), 32'd0);
        end

        // start in the done cycle is taken immediately
        push_exp(2'd1, 6'o07, 12'o0077);
        run_frame(18'b111111111_000000000, 1'b1, -1, 1'b0, 1'b0);
        push_exp(2'd1, 6'o13, 12'o0521);
        run_frame(18'b011010001_001000101, 1'b1, -1, 1'b0, 1'b0);
        tick();
        tick();
        check("b2b_pulses_seen", sb.size(), 32'd0);

        // asynchronous reset after 5 bits
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bit_in    = 1'b1;
            bit_valid = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        #2;
        model_func = '0;
        model_ins  = '0;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_ready", {31'd0, bit_ready}, 32'd0);
        check("arst_func", {26'd0, conf_func_bus}, 32'd0);
        check("arst_ins", {20'd0, conf_ins_bus}, 32'd0);
        check("arst_done_err", {30'd0, done, err}, 32'd0);
        tick();
        rst_n = 1'b1;
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_ready", {31'd0, bit_ready}, 32'd0);
        end
        bit_valid = 1'b0;

        // a clean frame after reset still loads
        push_exp(2'd1, 6'o13, 12'o0521);
        run_frame(18'b011010001_001000101, 1'b1, -1, 1'b1, 1'b0);
        tick();
        tick();
        check("post_rst_load", sb.size(), 32'd0);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chromosome_loader.md
CHROMOSOME_LOADER -- requirements
Module: chromosome_loader

Interface
REQ-001 The block SHALL have parameter N_LE, default 8, legal range 1..64, giving the number of logic elements configured.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: requests a new chromosome load.
REQ-005 The block SHALL have port abort, input, 1 bit: cancels a load in progress.
REQ-006 The block SHALL have port bit_in, input, 1 bit: serial chromosome data.
REQ-007 The block SHALL have port bit_valid, input, 1 bit: bit_in is valid this cycle.
REQ-008 The block SHALL have port bit_ready, output, 1 bit: the block accepts a bit this cycle.
REQ-009 The block SHALL have port conf_func_bus, output, 3*N_LE bits: per-LE function select; LE k uses bits [3k+2:3k].
REQ-010 The block SHALL have port conf_ins_bus, output, 6*N_LE bits: per-LE input select; LE k uses bits [6k+5:6k].
REQ-011 The block SHALL have port busy, output, 1 bit: a load is in progress.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse when a new configuration is committed.
REQ-013 The block SHALL have port err, output, 1 bit: one-cycle pulse when a load is rejected on parity.

Function
REQ-014 The FSM SHALL have exactly two states, IDLE and SHIFT; busy = bit_ready = (state == SHIFT).
REQ-015 In IDLE, start = 1 SHALL move the FSM to SHIFT on the next edge, clearing the bit counter and the running parity; a bit_valid asserted in that same cycle SHALL be ignored.
REQ-016 In SHIFT, start SHALL be ignored.
REQ-017 A bit SHALL be accepted on an edge where bit_valid and bit_ready are both 1; cycles with bit_valid = 0 SHALL leave all state unchanged (gaps of any length are legal).
REQ-018 A frame SHALL be N_LE*9 data bits followed by 1 parity bit.
REQ-019 Gene 0 SHALL be sent first; each gene SHALL be sent MSB first as {func[2:0], ins[5:0]}.
REQ-020 Data bits SHALL be written only into a shadow register bank; conf_func_bus and conf_ins_bus SHALL NOT change during SHIFT.
REQ-021 The running parity SHALL be the XOR of all accepted data bits; the frame is valid when the parity bit equals the running parity (even parity over the whole frame).
REQ-022 On the edge accepting a valid parity bit, the block SHALL copy the shadow bank to the output buses, set done = 1 for exactly the following cycle, and return to IDLE.
REQ-023 On the edge accepting an invalid parity bit, the output buses SHALL keep their previous values, err SHALL be 1 for exactly the following cycle, and the FSM SHALL return to IDLE.
REQ-024 abort = 1 in SHIFT SHALL return the FSM to IDLE on the next edge, discarding the shadow bank with no done or err pulse; abort SHALL win over a simultaneous accepted bit, including the parity bit.
REQ-025 abort in IDLE SHALL have no effect.
REQ-026 done and err SHALL never be 1 in the same cycle.
REQ-027 The bit counter SHALL be wide enough to hold N_LE*9 and SHALL NOT wrap within a frame.
REQ-028 A new start SHALL be accepted in the cycle done or err is high, since the FSM is then in IDLE.

Reset
REQ-029 rst_n = 0 SHALL immediately force: state IDLE, bit_ready = 0, busy = 0, done = 0, err = 0, counter = 0, parity = 0, shadow bank = 0, conf_func_bus = 0, conf_ins_bus = 0.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame; after release the block SHALL wait in IDLE for start.

Verification (N_LE = 2)
REQ-031 Reset then idle -> both buses 0, busy = 0, done = 0, err = 0.
REQ-032 Start, then bits 011010001, 001000101, parity 1, with random bit_valid gaps -> done for 1 cycle; conf_func_bus = 6'o13, conf_ins_bus = 12'o0521; bus unchanged before the parity edge.
REQ-033 Same frame with parity 0 -> err for 1 cycle; buses keep their prior values (0 after reset, or 6'o13/12'o0521 if loaded).
REQ-034 abort asserted together with the 10th bit -> IDLE next cycle, no done/err, buses unchanged; a following valid frame loads correctly.
REQ-035 start pulsed during SHIFT, and bit_valid held during the start cycle in IDLE -> both ignored; the frame still completes with the correct values.
REQ-036 rst_n pulled low asynchronously after 5 bits -> all outputs 0 immediately; after release, bit_ready = 0 until start.
